// File: rtl/dig_ct_sequencer_if.sv
// Bus bundle between the gate-network test sequencer and its harness.
// The sequencer side is the slave; the harness or top level is the master.
interface dig_ct_sequencer_if;
  logic       start;
  logic       abort;
  logic [2:0] dut_out;
  logic [4:0] dut_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] err_cnt;
  logic [4:0] first_err_vec;
  logic [2:0] err_mask;

  modport slave (
    input  start, abort, dut_out,
    output dut_in, busy, done, pass, err_cnt, first_err_vec, err_mask
  );

  modport master (
    output start, abort, dut_out,
    input  dut_in, busy, done, pass, err_cnt, first_err_vec, err_mask
  );
endinterface

// File: rtl/dig_ct_sequencer.sv
// Exhaustive 32-vector sweep of a 5-in/3-out gate network.
// Each vector is compared with the network response LATENCY cycles after it is driven.
module dig_ct_sequencer #(
  parameter int LATENCY = 1
) (
  input logic               clk,
  input logic               rst_n,
  dig_ct_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  function automatic logic [2:0] expect_of(input logic [4:0] v);
    logic [2:0] e;
    e[0] = ~(~(v[0] | v[1]) & v[2]);
    e[1] = ~(v[1] & v[2]);
    e[2] = v[2] | ~v[3] | v[4];
    return e;
  endfunction

  logic [1:0]                 state_q, state_d;
  logic [4:0]                 dut_in_q, dut_in_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       pass_q, pass_d;
  logic [5:0]                 err_cnt_q, err_cnt_d;
  logic [4:0]                 first_q, first_d;
  logic [2:0]                 mask_q, mask_d;
  logic [1:0]                 drain_q, drain_d;
  logic [LATENCY-1:0]         vld_q, vld_d;
  logic [LATENCY-1:0][4:0]    pv_q, pv_d;
  logic [LATENCY-1:0][2:0]    pe_q, pe_d;
  logic                       cmp_vld_s;
  logic [2:0]                 miss_s;

  // Next-state: compare pipeline tail, then sequence control (abort overrides the compare)
  always_comb begin
    state_d   = state_q;
    dut_in_d  = dut_in_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    mask_d    = mask_q;
    drain_d   = drain_q;
    vld_d     = '0;
    pv_d      = '0;
    pe_d      = '0;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      pv_d[i]  = pv_q[i-1];
      pe_d[i]  = pe_q[i-1];
    end

    cmp_vld_s = vld_q[LATENCY-1];
    miss_s    = bus.dut_out ^ pe_q[LATENCY-1];
    if (cmp_vld_s && (miss_s != 3'd0)) begin
      err_cnt_d = err_cnt_q + 6'd1;
      mask_d    = mask_q | miss_s;
      if (err_cnt_q == 6'd0) begin
        first_d = pv_q[LATENCY-1];
      end else begin
        first_d = first_q;
      end
    end else begin
      err_cnt_d = err_cnt_q;
    end

    case (state_q)
      S_IDLE, S_REPORT: begin
        if (bus.start && !bus.abort) begin
          state_d   = S_DRIVE;
          busy_d    = 1'b1;
          dut_in_d  = 5'd0;
          pass_d    = 1'b0;
          err_cnt_d = 6'd0;
          first_d   = 5'd0;
          mask_d    = 3'd0;
          vld_d[0]  = 1'b1;
          pv_d[0]   = 5'd0;
          pe_d[0]   = expect_of(5'd0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE, S_DRAIN: begin
        if (bus.abort) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          dut_in_d  = 5'd0;
          pass_d    = 1'b0;
          err_cnt_d = err_cnt_q;
          first_d   = first_q;
          mask_d    = mask_q;
          vld_d     = '0;
        end else if (state_q == S_DRIVE) begin
          if (dut_in_q == 5'd31) begin
            state_d  = S_DRAIN;
            dut_in_d = 5'd0;
            drain_d  = 2'd0;
          end else begin
            dut_in_d = dut_in_q + 5'd1;
            vld_d[0] = 1'b1;
            pv_d[0]  = dut_in_q + 5'd1;
            pe_d[0]  = expect_of(dut_in_q + 5'd1);
          end
        end else if (drain_q == 2'(LATENCY - 1)) begin
          state_d = S_REPORT;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == 6'd0);
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        dut_in_d = 5'd0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dut_in_q  <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= 6'd0;
      first_q   <= 5'd0;
      mask_q    <= 3'd0;
      drain_q   <= 2'd0;
      vld_q     <= '0;
      pv_q      <= '0;
      pe_q      <= '0;
    end else begin
      state_q   <= state_d;
      dut_in_q  <= dut_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      mask_q    <= mask_d;
      drain_q   <= drain_d;
      vld_q     <= vld_d;
      pv_q      <= pv_d;
      pe_q      <= pe_d;
    end
  end

  assign bus.dut_in        = dut_in_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.first_err_vec = first_q;
  assign bus.err_mask      = mask_q;

endmodule

// File: tb/tb_dig_ct_sequencer.sv
// Bench for dig_ct_sequencer: a fault-injectable gate network drives DUT_OUT, and a
// vector-loop reference model predicts the sweep result for each fault configuration.
module tb_dig_ct_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dig_ct_sequencer_if if1();
  dig_ct_sequencer_if if3();

  dig_ct_sequencer #(.LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  dig_ct_sequencer #(.LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int checks = 0;
  int errors = 0;

  // fault configuration applied to the network feeding u_dut1
  logic [2:0]  sa_mask   = 3'b000;
  logic [2:0]  sa_val    = 3'b000;
  logic [2:0]  flip_bits = 3'b000;
  logic [31:0] flip_set  = 32'd0;
  int          extra3    = 2;
  logic [4:0]  d1, d2;

  // gate-level view of the network: NOR/AND-NOT, NAND, OR with inverter
  function automatic logic [2:0] gate_net(input logic [4:0] v);
    logic n12;
    n12 = ~(v[0] | v[1]);
    return {v[2] | ~v[3] | v[4], ~(v[1] & v[2]), ~(n12 & v[2])};
  endfunction

  function automatic logic [2:0] faulty(input logic [4:0] v);
    logic [2:0] r;
    r = gate_net(v);
    if (flip_set[v]) r = r ^ flip_bits;
    return (r & ~sa_mask) | (sa_val & sa_mask);
  endfunction

  always_comb if1.dut_out = faulty(if1.dut_in);

  always_ff @(posedge clk) begin
    d1 <= if3.dut_in;
    d2 <= d1;
  end
  always_comb if3.dut_out = gate_net((extra3 == 2) ? d2 : d1);

  // reference: walk the first nvec vectors, compare the faulty response with the truth table
  task automatic ref_sweep(input int nvec, output int errs, output logic [4:0] first,
                           output logic [2:0] mask);
    logic [4:0] vv;
    logic [2:0] e, o;
    errs = 0; first = 5'd0; mask = 3'd0;
    for (int v = 0; v < nvec; v++) begin
      vv = v[4:0];
      e[0] = vv[0] | vv[1] | ~vv[2];
      e[1] = ~(vv[1] & vv[2]);
      e[2] = vv[2] | ~vv[3] | vv[4];
      o = faulty(vv);
      if (o != e) begin
        if (errs == 0) first = vv;
        errs++;
        mask = mask | (o ^ e);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] cur_in(input int sel);
    return (sel == 1) ? if1.dut_in : if3.dut_in;
  endfunction

  function automatic logic cur_done(input int sel);
    return (sel == 1) ? if1.done : if3.done;
  endfunction

  // pulse START for one edge, then count edges until DONE (lat = -1 on timeout)
  task automatic sweep(input int sel, output int lat, output logic walk_ok);
    @(negedge clk);
    if (sel == 1) if1.start = 1'b1; else if3.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0; if3.start = 1'b0;
    walk_ok = (cur_in(sel) == 5'd0);
    lat = -1;
    for (int e = 1; e < 100; e++) begin
      @(posedge clk); #1;
      if (e < 32 && cur_in(sel) != 5'(e)) walk_ok = 1'b0;
      if (e == 32 && cur_in(sel) != 5'd0) walk_ok = 1'b0;
      if (cur_done(sel)) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic check_res1(input logic p, input int n, input logic [4:0] f, input logic [2:0] m);
    check("pass", {31'd0, if1.pass}, {31'd0, p});
    check("err_cnt", {26'd0, if1.err_cnt}, n);
    check("first_err_vec", {27'd0, if1.first_err_vec}, {27'd0, f});
    check("err_mask", {29'd0, if1.err_mask}, {29'd0, m});
  endtask

  int         lat, rn, nd, busy_seen;
  logic       wok;
  logic [4:0] rf;
  logic [2:0] rm;

  initial begin
    rst_n = 1'b1;
    if1.start = 1'b0; if1.abort = 1'b0;
    if3.start = 1'b0; if3.abort = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, if1.busy}, 32'd0);
    check("rst_done", {31'd0, if1.done}, 32'd0);
    check("rst_dut_in", {27'd0, if1.dut_in}, 32'd0);
    check_res1(1'b0, 0, 5'd0, 3'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // clean network, LATENCY=1
    sweep(1, lat, wok);
    check("clean_latency", lat, 32'd33);
    check("clean_walk", {31'd0, wok}, 32'd1);
    check_res1(1'b1, 0, 5'd0, 3'd0);
    @(posedge clk); #1;
    check("done_pulse", {31'd0, if1.done}, 32'd0);

    // OUT2 stuck-at-0
    sa_mask = 3'b010; sa_val = 3'b000;
    sweep(1, lat, wok);
    check("sa0_out2_latency", lat, 32'd33);
    check_res1(1'b0, 24, 5'd0, 3'b010);

    // OUT3 stuck-at-1
    sa_mask = 3'b100; sa_val = 3'b100;
    sweep(1, lat, wok);
    check_res1(1'b0, 4, 5'd8, 3'b100);

    // OUT1 stuck-at-1
    sa_mask = 3'b001; sa_val = 3'b001;
    sweep(1, lat, wok);
    check_res1(1'b0, 4, 5'd4, 3'b001);

    // randomized fault configurations against the reference model
    for (int r = 0; r < 8; r++) begin
      sa_mask   = 3'($urandom_range(0, 7));
      sa_val    = 3'($urandom_range(0, 7));
      flip_bits = 3'($urandom_range(1, 7));
      flip_set  = $urandom & $urandom & $urandom;
      if (r == 0) begin sa_mask = 3'd0; flip_set = 32'd0; end
      ref_sweep(32, rn, rf, rm);
      sweep(1, lat, wok);
      check("rnd_latency", lat, 32'd33);
      check_res1(rn == 0, rn, rf, rm);
    end

    // LATENCY=3 with a matching 3-stage network, then a 2-stage network
    extra3 = 2;
    sweep(3, lat, wok);
    check("lat3_latency", lat, 32'd35);
    check("lat3_walk", {31'd0, wok}, 32'd1);
    check("lat3_pass", {31'd0, if3.pass}, 32'd1);
    check("lat3_err_cnt", {26'd0, if3.err_cnt}, 32'd0);
    extra3 = 1;
    sweep(3, lat, wok);
    check("lat3_short_net_pass", {31'd0, if3.pass}, 32'd0);

    // ABORT while vector 10 is driven; compares of vectors 0..9 are kept
    sa_mask = 3'b010; sa_val = 3'b000; flip_set = 32'd0;
    @(negedge clk); if1.start = 1'b1;
    @(posedge clk); #1; if1.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("abort_at_vec", {27'd0, if1.dut_in}, 32'd10);
    if1.abort = 1'b1;
    @(posedge clk); #1;
    if1.abort = 1'b0;
    check("abort_busy", {31'd0, if1.busy}, 32'd0);
    check("abort_dut_in", {27'd0, if1.dut_in}, 32'd0);
    ref_sweep(10, rn, rf, rm);
    check_res1(1'b0, rn, rf, rm);
    nd = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (if1.done || if1.busy) nd++;
    end
    check("abort_quiet", nd, 32'd0);

    // START held during DRIVE has no effect
    sa_mask = 3'b000;
    @(negedge clk); if1.start = 1'b1;
    @(posedge clk); #1; if1.start = 1'b0;
    nd = 0; lat = -1;
    for (int e = 1; e < 60; e++) begin
      @(posedge clk); #1;
      if (e == 5) if1.start = 1'b1;
      if (e == 6) if1.start = 1'b0;
      if (if1.done) begin
        nd++;
        if (lat < 0) lat = e;
      end
    end
    check("restart_done_count", nd, 32'd1);
    check("restart_latency", lat, 32'd33);
    check("restart_pass", {31'd0, if1.pass}, 32'd1);

    // reset mid-sweep at vector 20
    sa_mask = 3'b010; sa_val = 3'b000;
    @(negedge clk); if1.start = 1'b1;
    @(posedge clk); #1; if1.start = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    check("rst_at_vec", {27'd0, if1.dut_in}, 32'd20);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, if1.busy}, 32'd0);
    check("midrst_dut_in", {27'd0, if1.dut_in}, 32'd0);
    check_res1(1'b0, 0, 5'd0, 3'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sa_mask = 3'b000;
    nd = 0; busy_seen = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (if1.done) nd++;
      if (if1.busy) busy_seen++;
    end
    check("post_rst_done", nd, 32'd0);
    check("post_rst_busy", busy_seen, 32'd0);
    sweep(1, lat, wok);
    check("post_rst_latency", lat, 32'd33);
    check_res1(1'b1, 0, 5'd0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dig_ct_sequencer.md
DIG_CT_SEQUENCER -- requirements
Module: dig_ct_sequencer

Interface
REQ-001 Parameter: LATENCY, default 1, number of register stages between DUT_IN and DUT_OUT of the gate network under sequence; legal range 1..4.
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RST_N  in  1  reset; asynchronous assertion, active-low.
REQ-004 START  in  1  run request; sampled on a rising edge; ignored unless FSM is IDLE or REPORT.
REQ-005 ABORT  in  1  cancels a running sweep; has priority over START.
REQ-006 DUT_OUT  in  3  gate network outputs; bit0=OUT1, bit1=OUT2, bit2=OUT3.
REQ-007 DUT_IN  out  5  registered stimulus to gate network; bit0=IN1 .. bit4=IN5.
REQ-008 BUSY  out  1  high in DRIVE and DRAIN.
REQ-009 DONE  out  1  one-cycle pulse, high only in REPORT.
REQ-010 PASS  out  1  sweep result: 1 when ERR_CNT==0; valid from DONE until the next run starts.
REQ-011 ERR_CNT  out  6  number of vectors with at least one output mismatch (0..32, no saturation needed).
REQ-012 FIRST_ERR_VEC  out  5  first mismatching vector; holds 0 when ERR_CNT==0.
REQ-013 ERR_MASK  out  3  sticky OR of mismatching output bits over the sweep.

Function
REQ-014 FSM states: IDLE, DRIVE, DRAIN, REPORT; all outputs registered.
REQ-015 IDLE/REPORT + START=1 & ABORT=0 -> DRIVE; clears ERR_CNT, ERR_MASK, FIRST_ERR_VEC, PASS; vector counter := 0.
REQ-016 DRIVE: DUT_IN = vector counter; counter increments by 1 per cycle, 0..31; after vector 31 is driven -> DRAIN.
REQ-017 DRAIN: lasts exactly LATENCY cycles; DUT_IN holds 0; then -> REPORT.
REQ-018 REPORT: one cycle; DONE=1, PASS updated; then -> IDLE unless START restarts it.
REQ-019 Expected value per vector v: E0 = ~(~(IN1|IN2)&IN3), E1 = ~(IN2&IN3), E2 = IN3|~IN4|IN5.
REQ-020 Vector, expected value and a valid flag travel through a LATENCY-deep pipeline; vector presented after edge t is compared with DUT_OUT at edge t+LATENCY.
REQ-021 On a valid compare with DUT_OUT != E: ERR_CNT += 1; ERR_MASK |= (DUT_OUT ^ E); FIRST_ERR_VEC := v only if ERR_CNT was 0.
REQ-022 DONE asserted after the (32+LATENCY)th rising edge following the edge that sampled START; PASS reflects all 32 compares.
REQ-023 Vector counter wrap 31->0 does not occur within a run; exactly 32 vectors, each compared once.
REQ-024 ABORT=1 in DRIVE/DRAIN -> IDLE at next edge; pipeline valid flags cleared; DUT_IN := 0; DONE not pulsed; PASS := 0; error outputs hold partial values.
REQ-025 START while BUSY has no effect; START and ABORT together in IDLE: stays IDLE.
REQ-026 IDLE: DUT_IN = 0, no compares, result outputs hold.

Reset
REQ-027 RST_N=0 forces immediately: state IDLE, DUT_IN=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_ERR_VEC=0, ERR_MASK=0, pipeline valid flags 0.
REQ-028 Reset mid-sweep abandons the run; no DONE follows reset release without a new START.

Verification
REQ-029 Correct gate-network model, LATENCY=1, START pulse -> DONE 33 edges later, PASS=1, ERR_CNT=0, ERR_MASK=000, DUT_IN walked 0..31.
REQ-030 OUT2 stuck-at-0 -> PASS=0, ERR_CNT=24, FIRST_ERR_VEC=0, ERR_MASK=010.
REQ-031 OUT3 stuck-at-1 -> ERR_CNT=4, FIRST_ERR_VEC=8, ERR_MASK=100; OUT1 stuck-at-1 -> ERR_CNT=4, FIRST_ERR_VEC=4, ERR_MASK=001.
REQ-032 LATENCY=3, model delayed 3 stages -> PASS=1, DONE 35 edges after START; same model with LATENCY=2 -> PASS=0.
REQ-033 ABORT at vector 10 -> IDLE next edge, BUSY=0, no DONE, PASS=0; START asserted during DRIVE -> sweep unaffected, single DONE.
REQ-034 RST_N low at vector 20 -> all outputs reset values immediately; after release, no activity until START; next full run -> PASS=1.
